// File: rtl/vx_wb_arb_pkg.sv
// Shared types and constants for the commit/writeback arbiter.
// Optional feature macro: VX_WB_ARB_PERF_EN (per-unit stall counters on the top).
package vx_wb_arb_pkg;

    // Requester index order on the commit bus
    localparam int WB_REQ_ALU = 0;
    localparam int WB_REQ_LD  = 1;
    localparam int WB_REQ_CSR = 2;
    localparam int WB_REQ_FPU = 3;
    localparam int WB_REQ_GPU = 4;

    // Default core geometry; commit_t is laid out for these sizes
    localparam int WB_NUM_REQS    = 5;
    localparam int WB_NUM_THREADS = 4;
    localparam int WB_NUM_WARPS   = 4;
    localparam int WB_NR_BITS     = 5;
    localparam int WB_DATA_WIDTH  = 32;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WB_WIDW = clog2_min1(WB_NUM_WARPS);

    typedef struct packed {
        logic [WB_WIDW-1:0]                                wid;
        logic [31:0]                                       pc;
        logic [WB_NUM_THREADS-1:0]                         tmask;
        logic                                              wb;
        logic [WB_NR_BITS-1:0]                             rd;
        logic [WB_NUM_THREADS-1:0][WB_DATA_WIDTH-1:0]      data;
    } commit_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: one-hot and binary grant, search starts one past the
// last accepted grant and wraps. The pointer only moves when accept_i is high,
// so a refused grant is offered again with the same priority next cycle.
module vx_rr_arbiter
    import vx_wb_arb_pkg::*;
#(
    parameter  int NUM_REQS = 5,
    localparam int IDXW     = clog2_min1(NUM_REQS)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_REQS-1:0] req_i,
    input  logic                accept_i,
    output logic [NUM_REQS-1:0] grant_oh_o,
    output logic [IDXW-1:0]     grant_idx_o,
    output logic                grant_valid_o
);

    logic [IDXW-1:0] last_q, last_d;

    // Two passes: indices above the pointer first, then wrap to the low ones
    always_comb begin
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int j = 0; j < NUM_REQS; j++) begin
            if (!grant_valid_o && req_i[j] && (j > int'(last_q))) begin
                grant_valid_o  = 1'b1;
                grant_oh_o[j]  = 1'b1;
                grant_idx_o    = IDXW'(j);
            end
        end
        for (int j = 0; j < NUM_REQS; j++) begin
            if (!grant_valid_o && req_i[j] && (j <= int'(last_q))) begin
                grant_valid_o  = 1'b1;
                grant_oh_o[j]  = 1'b1;
                grant_idx_o    = IDXW'(j);
            end
        end
    end

    // Pointer advances only on an accepted grant
    always_comb begin
        last_d = last_q;
        if (accept_i && grant_valid_o) last_d = grant_idx_o;
    end

    // Pointer register; reset makes requester 0 highest priority
    always_ff @(posedge clk_i) begin
        if (reset_i) last_q <= IDXW'(NUM_REQS - 1);
        else         last_q <= last_d;
    end

endmodule

// File: rtl/vx_commit_wb_arbiter.sv
// Commit -> register-file writeback arbiter. Merges the execute units' commit
// streams into one registered writeback port with valid/ready backpressure.
// Commits that do not write the register file are acknowledged immediately.
// Optional feature macro: VX_WB_ARB_PERF_EN adds perf_stalls_o counters.
module vx_commit_wb_arbiter
    import vx_wb_arb_pkg::*;
#(
    parameter  int NUM_REQS    = 5,
    parameter  int NUM_THREADS = 4,
    parameter  int NUM_WARPS   = 4,
    parameter  int NR_BITS     = 5,
    parameter  int DATA_WIDTH  = 32,
    localparam int WIDW        = clog2_min1(NUM_WARPS),
    localparam int IDXW        = clog2_min1(NUM_REQS)
) (
    input  logic                                               clk_i,
    input  logic                                               reset_i,
    input  logic [NUM_REQS-1:0]                                req_valid_i,
    output logic [NUM_REQS-1:0]                                req_ready_o,
    input  logic [NUM_REQS-1:0][WIDW-1:0]                      req_wid_i,
    input  logic [NUM_REQS-1:0][31:0]                          req_pc_i,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]               req_tmask_i,
    input  logic [NUM_REQS-1:0]                                req_wb_i,
    input  logic [NUM_REQS-1:0][NR_BITS-1:0]                   req_rd_i,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][DATA_WIDTH-1:0] req_data_i,
    output logic                                               wb_valid_o,
    input  logic                                               wb_ready_i,
    output logic [WIDW-1:0]                                    wb_wid_o,
    output logic [31:0]                                        wb_pc_o,
    output logic [NUM_THREADS-1:0]                             wb_tmask_o,
    output logic [NR_BITS-1:0]                                 wb_rd_o,
    output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]             wb_data_o
`ifdef VX_WB_ARB_PERF_EN
    ,
    output logic [NUM_REQS-1:0][31:0]                          perf_stalls_o
`endif
);

    logic                    stall;
    logic [NUM_REQS-1:0]     arb_req;
    logic [NUM_REQS-1:0]     gnt_oh;
    logic [IDXW-1:0]         gnt_idx;
    logic                    gnt_valid;

    logic                                   wb_valid_q, wb_valid_d;
    logic [WIDW-1:0]                        wb_wid_q,   wb_wid_d;
    logic [31:0]                            wb_pc_q,    wb_pc_d;
    logic [NUM_THREADS-1:0]                 wb_tmask_q, wb_tmask_d;
    logic [NR_BITS-1:0]                     wb_rd_q,    wb_rd_d;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] wb_data_q,  wb_data_d;

    // Held entry not taken downstream blocks the whole output register
    assign stall   = wb_valid_q & ~wb_ready_i;
    // Only register-writing commits compete for the port
    assign arb_req = req_valid_i & req_wb_i;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_rr (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_i         (arb_req),
        .accept_i      (~stall),
        .grant_oh_o    (gnt_oh),
        .grant_idx_o   (gnt_idx),
        .grant_valid_o (gnt_valid)
    );

    // wb=0 commits are acked on the spot; wb=1 only when granted and not stalled
    always_comb begin
        req_ready_o = (req_valid_i & ~req_wb_i) | (gnt_oh & {NUM_REQS{~stall}});
    end

    // Output register next state: load granted payload, bubble if nothing to send
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_wid_d   = wb_wid_q;
        wb_pc_d    = wb_pc_q;
        wb_tmask_d = wb_tmask_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (!stall) begin
            wb_valid_d = gnt_valid;
            if (gnt_valid) begin
                wb_wid_d   = req_wid_i[gnt_idx];
                wb_pc_d    = req_pc_i[gnt_idx];
                wb_tmask_d = req_tmask_i[gnt_idx];
                wb_rd_d    = req_rd_i[gnt_idx];
                wb_data_d  = req_data_i[gnt_idx];
            end
        end
    end

    // Output register; reset discards any held entry
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wb_valid_q <= 1'b0;
            wb_wid_q   <= '0;
            wb_pc_q    <= '0;
            wb_tmask_q <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_wid_q   <= wb_wid_d;
            wb_pc_q    <= wb_pc_d;
            wb_tmask_q <= wb_tmask_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_wid_o   = wb_wid_q;
    assign wb_pc_o    = wb_pc_q;
    assign wb_tmask_o = wb_tmask_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;

`ifdef VX_WB_ARB_PERF_EN
    logic [NUM_REQS-1:0][31:0] perf_q, perf_d;
    logic [NUM_REQS-1:0]       blocked;

    assign blocked = arb_req & ~req_ready_o;

    // Saturating per-unit count of cycles a writeback commit waited
    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (blocked[i] && (perf_q[i] != 32'hFFFF_FFFF)) perf_d[i] = perf_q[i] + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) perf_q <= '0;
        else         perf_q <= perf_d;
    end

    assign perf_stalls_o = perf_q;
`endif

`ifndef SYNTHESIS
    // A pending writeback commit must hold its request and payload until taken
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_hold_chk
        a_hold: assert property (@(posedge clk_i) disable iff (reset_i)
            (req_valid_i[i] && req_wb_i[i] && !req_ready_o[i]) |=>
            (req_valid_i[i] && req_wb_i[i] && $stable(req_wid_i[i]) && $stable(req_pc_i[i]) &&
             $stable(req_tmask_i[i]) && $stable(req_rd_i[i]) && $stable(req_data_i[i])));
    end
`endif

endmodule

// File: tb/tb_vx_commit_wb_arbiter.sv
// Bench for vx_commit_wb_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_vx_commit_wb_arbiter;
    import vx_wb_arb_pkg::*;

    localparam int NR   = 5;
    localparam int NT   = 4;
    localparam int NW   = 4;
    localparam int WIDW = 2;
    localparam int NRB  = 5;
    localparam int DW   = 32;

    logic                          clk_i = 1'b0;
    logic                          reset_i = 1'b1;
    logic [NR-1:0]                 req_valid = '0;
    logic [NR-1:0]                 req_ready_o;
    logic [NR-1:0][WIDW-1:0]       req_wid = '0;
    logic [NR-1:0][31:0]           req_pc = '0;
    logic [NR-1:0][NT-1:0]         req_tmask = '0;
    logic [NR-1:0]                 req_wb = '0;
    logic [NR-1:0][NRB-1:0]        req_rd = '0;
    logic [NR-1:0][NT-1:0][DW-1:0] req_data = '0;
    logic                          wb_valid_o;
    logic                          wb_ready = 1'b1;
    logic [WIDW-1:0]               wb_wid_o;
    logic [31:0]                   wb_pc_o;
    logic [NT-1:0]                 wb_tmask_o;
    logic [NRB-1:0]                wb_rd_o;
    logic [NT-1:0][DW-1:0]         wb_data_o;
`ifdef VX_WB_ARB_PERF_EN
    logic [NR-1:0][31:0]           perf_stalls_o;
`endif

    vx_commit_wb_arbiter #(
        .NUM_REQS(NR), .NUM_THREADS(NT), .NUM_WARPS(NW), .NR_BITS(NRB), .DATA_WIDTH(DW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_wid_i   (req_wid),
        .req_pc_i    (req_pc),
        .req_tmask_i (req_tmask),
        .req_wb_i    (req_wb),
        .req_rd_i    (req_rd),
        .req_data_i  (req_data),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready),
        .wb_wid_o    (wb_wid_o),
        .wb_pc_o     (wb_pc_o),
        .wb_tmask_o  (wb_tmask_o),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o)
`ifdef VX_WB_ARB_PERF_EN
        ,
        .perf_stalls_o (perf_stalls_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_valid = 1'b0;
    int            m_lg = NR - 1;
    commit_t       m_e;
    logic [NR-1:0] m_rdy;
`ifdef VX_WB_ARB_PERF_EN
    logic [NR-1:0][31:0] m_cnt = '0;
`endif

    // Single compare process: outputs vs. model, then advance model over the edge
    always @(negedge clk_i) begin
        if (chk_en) begin
            int g;
            bit st;
            chk("wb_valid", wb_valid_o, m_valid);
            if (m_valid) begin
                chk("wb_wid", wb_wid_o, m_e.wid);
                chk("wb_pc", wb_pc_o, m_e.pc);
                chk("wb_tmask", wb_tmask_o, m_e.tmask);
                chk("wb_rd", wb_rd_o, m_e.rd);
                chk("wb_data", wb_data_o, m_e.data);
            end
`ifdef VX_WB_ARB_PERF_EN
            for (int i = 0; i < NR; i++) chk($sformatf("perf_%0d", i), perf_stalls_o[i], m_cnt[i]);
`endif
            if (reset_i) begin
                m_valid = 1'b0;
                m_lg    = NR - 1;
`ifdef VX_WB_ARB_PERF_EN
                m_cnt   = '0;
`endif
            end else begin
                st = m_valid && !wb_ready;
                g  = -1;
                if (!st) begin
                    for (int k = 1; k <= NR; k++) begin
                        int j;
                        j = (m_lg + k) % NR;
                        if (g < 0 && req_valid[j] && req_wb[j]) g = j;
                    end
                end
                for (int i = 0; i < NR; i++) m_rdy[i] = (req_valid[i] && !req_wb[i]) || (i == g);
                chk("req_ready", req_ready_o, m_rdy);
`ifdef VX_WB_ARB_PERF_EN
                for (int i = 0; i < NR; i++)
                    if (req_valid[i] && req_wb[i] && !m_rdy[i] && m_cnt[i] != 32'hFFFF_FFFF)
                        m_cnt[i] = m_cnt[i] + 32'd1;
`endif
                if (!st) begin
                    if (g >= 0) begin
                        m_valid   = 1'b1;
                        m_lg      = g;
                        m_e.wid   = req_wid[g];
                        m_e.pc    = req_pc[g];
                        m_e.tmask = req_tmask[g];
                        m_e.wb    = 1'b1;
                        m_e.rd    = req_rd[g];
                        m_e.data  = req_data[g];
                    end else begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_unit(input int i, input bit wb, input logic [NRB-1:0] rd,
                            input logic [31:0] d, input logic [NT-1:0] tm);
        req_valid[i] = 1'b1;
        req_wb[i]    = wb;
        req_rd[i]    = rd;
        req_wid[i]   = WIDW'(i);
        req_pc[i]    = 32'h100 + 32'(i * 4);
        req_tmask[i] = tm;
        for (int l = 0; l < NT; l++) req_data[i][l] = d;
    endtask

    task automatic rand_unit(input int i);
        req_valid[i] = 1'b1;
        req_wb[i]    = ($urandom_range(0, 4) != 0);
        req_rd[i]    = NRB'($urandom);
        req_wid[i]   = WIDW'($urandom);
        req_pc[i]    = $urandom;
        req_tmask[i] = NT'($urandom);
        for (int l = 0; l < NT; l++) req_data[i][l] = $urandom;
    endtask

    // Called at a negedge; retires accepted requests until none remain
    task automatic drain();
        logic [NR-1:0] took;
        int n;
        n = 0;
        while (req_valid != '0 && n < 20) begin
            took = req_valid & req_ready_o;
            @(posedge clk_i); #1;
            req_valid = req_valid & ~took;
            @(negedge clk_i);
            n++;
        end
        chk("drain_done", req_valid, '0);
    endtask

    logic [NT-1:0][DW-1:0] beef;
    logic [NR-1:0]         took_r;
    int                    pulses;

    initial begin
        beef = {NT{32'hDEAD_BEEF}};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1 chk_en = 1'b1;
        @(negedge clk_i);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_rd", wb_rd_o, 0);
        chk("rst_wb_pc", wb_pc_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        @(posedge clk_i); #1 reset_i = 1'b0;
        @(negedge clk_i);

        // 1: all units wb=1 continuously -> 0,1,2,3,4,0,1 with no bubbles
        @(posedge clk_i); #1;
        wb_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_unit(i, 1'b1, NRB'(10 + i), 32'(i), 4'hF);
        for (int k = 0; k < 7; k++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("t1_valid", wb_valid_o, 1);
            chk("t1_order_rd", wb_rd_o, 10 + (k % 5));
        end
        drain();

        // 2+3: held output under stall, wb=0 ack during stall
        @(posedge clk_i); #1;
        set_unit(2, 1'b1, 5'd7, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk_i);
        chk("t2_first_ready", req_ready_o[2], 1);
        pulses = int'(req_ready_o[2]);
        @(posedge clk_i); #1;
        set_unit(2, 1'b1, 5'd8, 32'h1234_5678, 4'hF);
        wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) set_unit(1, 1'b0, 5'd3, 32'h0, 4'hF);
            @(negedge clk_i);
            chk("t2_hold_valid", wb_valid_o, 1);
            chk("t2_hold_rd", wb_rd_o, 7);
            chk("t2_hold_data", wb_data_o, beef);
            pulses += int'(req_ready_o[2]);
            if (c == 1) chk("t3_wb0_ack", req_ready_o[1], 1);
            @(posedge clk_i); #1;
            if (c == 1) req_valid[1] = 1'b0;
        end
        chk("t2_ready_once", pulses, 1);
        wb_ready = 1'b1;
        @(negedge clk_i);
        chk("t2_regrant", req_ready_o, 5'b00100);
        @(posedge clk_i); #1 req_valid[2] = 1'b0;
        @(negedge clk_i);
        chk("t2_next_rd", wb_rd_o, 8);
        // Pointer still at 2 despite the wb=0 ack: unit 3 before unit 1
        @(posedge clk_i); #1;
        set_unit(0, 1'b0, 5'd0, 32'h0, 4'hF);
        set_unit(1, 1'b1, 5'd11, 32'h11, 4'hF);
        set_unit(3, 1'b1, 5'd13, 32'h13, 4'hF);
        @(negedge clk_i);
        chk("t3_ptr", req_ready_o, 5'b01001);
        drain();

        // 4: grant 3, then 0 and 4 -> 4 first, then wrap to 0; tmask=0 forwarded
        @(posedge clk_i); #1;
        set_unit(3, 1'b1, 5'd3, 32'h3, 4'hF);
        @(negedge clk_i);
        chk("t4_g3", req_ready_o, 5'b01000);
        @(posedge clk_i); #1;
        req_valid[3] = 1'b0;
        set_unit(0, 1'b1, 5'd20, 32'h20, 4'hF);
        set_unit(4, 1'b1, 5'd24, 32'h24, 4'h0);
        @(negedge clk_i);
        chk("t4_first", req_ready_o, 5'b10000);
        @(posedge clk_i); #1 req_valid[4] = 1'b0;
        @(negedge clk_i);
        chk("t4_rd4", wb_rd_o, 24);
        chk("t4_tmask0", wb_tmask_o, 0);
        chk("t4_second", req_ready_o, 5'b00001);
        @(posedge clk_i); #1 req_valid[0] = 1'b0;
        @(negedge clk_i);
        chk("t4_rd0", wb_rd_o, 20);

        // 5: reset while holding a stalled entry
        @(posedge clk_i); #1;
        set_unit(1, 1'b1, 5'd9, 32'h9, 4'hF);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        req_valid[1] = 1'b0;
        wb_ready = 1'b0;
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("t5_pre_valid", wb_valid_o, 1);
        @(posedge clk_i); #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("t5_post_valid", wb_valid_o, 0);
        chk("t5_post_rd", wb_rd_o, 0);
        @(posedge clk_i); #1;
        wb_ready = 1'b1;
        set_unit(0, 1'b1, 5'd1, 32'h1, 4'hF);
        set_unit(3, 1'b1, 5'd2, 32'h2, 4'hF);
        set_unit(4, 1'b1, 5'd3, 32'h3, 4'hF);
        @(negedge clk_i);
        chk("t5_order", req_ready_o, 5'b00001);
        drain();

`ifdef VX_WB_ARB_PERF_EN
        // 6: unit 0 blocked for 10 stalled cycles
        @(posedge clk_i); #1 reset_i = 1'b1;
        @(posedge clk_i); #1 reset_i = 1'b0;
        set_unit(1, 1'b1, 5'd1, 32'h1, 4'hF);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        req_valid[1] = 1'b0;
        wb_ready = 1'b0;
        set_unit(0, 1'b1, 5'd2, 32'h2, 4'hF);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk("t6_perf0", perf_stalls_o[0], 10);
        chk("t6_perf1", perf_stalls_o[1], 0);
        chk("t6_perf4", perf_stalls_o[4], 0);
        @(posedge clk_i); #1 wb_ready = 1'b1;
        @(negedge clk_i);
        drain();
`endif

        // Random traffic; pending wb=1 requests are held until accepted
        repeat (400) begin
            took_r = req_valid & req_ready_o;
            @(posedge clk_i); #1;
            wb_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || took_r[i]) begin
                    if ($urandom_range(0, 2) == 0) rand_unit(i);
                    else req_valid[i] = 1'b0;
                end
            end
            @(negedge clk_i);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
